huffman_decoder: RTL and testbench

- Bit-serial canonical Huffman decoder. It is the receive-side counterpart of the encoder in the Huffman accelerator.
- Consumes the encoder's code bitstream one bit per cycle, MSB of each codeword first, and emits one 8-bit symbol per completed codeword.
- The codebook is loaded as canonical tables: a per-length code count plus a symbol list in canonical order. Host software derives these from the same {code, length} table that drives the encoder.

---
 rtl/huffman_pkg.sv | 16 +
 rtl/huffman_decoder_if.sv | 39 +++
 rtl/huff_canon_tables.sv | 67 ++++++
 rtl/huffman_decoder.sv | 161 ++++++++++++++++
 tb/tb_huffman_decoder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_pkg.sv
// Shared constants and types for the bit-serial canonical Huffman decoder.
package huffman_pkg;

    localparam int MAX_LEN_DEFAULT = 16;
    localparam int SYM_W_DEFAULT   = 8;

    // Widths for the default configuration: codeword length field and code count field.
    localparam int LEN_W = $clog2(MAX_LEN_DEFAULT + 1);
    localparam int CNT_W = SYM_W_DEFAULT + 1;

    typedef enum logic [0:0] {
        DECODE = 1'b0,
        ERROR  = 1'b1
    } state_e;

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, bit-stream and symbol-stream signals of the Huffman decoder.
interface huffman_decoder_if
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int SYM_W   = SYM_W_DEFAULT
) ();
    localparam int L_W = $clog2(MAX_LEN + 1);

    logic             clr;
    logic             cnt_we;
    logic [L_W-1:0]   cnt_addr;
    logic [SYM_W:0]   cnt_data;
    logic             sym_we;
    logic [SYM_W-1:0] sym_addr;
    logic [SYM_W-1:0] sym_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic [L_W-1:0]   out_len;
    logic             busy;
    logic             err;

    modport master (
        output clr, cnt_we, cnt_addr, cnt_data, sym_we, sym_addr, sym_data,
               in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_sym, out_len, busy, err
    );

    modport slave (
        input  clr, cnt_we, cnt_addr, cnt_data, sym_we, sym_addr, sym_data,
               in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_sym, out_len, busy, err
    );

endinterface

// File: rtl/huff_canon_tables.sv
// Canonical codebook storage: per-length code counts and symbols in canonical order.
module huff_canon_tables
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int SYM_W   = SYM_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cnt_we_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cnt_waddr_i,
    input  logic [SYM_W:0]                 cnt_wdata_i,
    input  logic                           sym_we_i,
    input  logic [SYM_W-1:0]               sym_waddr_i,
    input  logic [SYM_W-1:0]               sym_wdata_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cnt_raddr_i,
    output logic [SYM_W:0]                 cnt_rdata_o,
    input  logic [SYM_W-1:0]               sym_raddr_i,
    output logic [SYM_W-1:0]               sym_rdata_o
);
    localparam int L_W   = $clog2(MAX_LEN + 1);
    localparam int C_W   = SYM_W + 1;
    localparam int SYM_N = 2 ** SYM_W;
    localparam logic [L_W-1:0] LEN_MAX = L_W'(MAX_LEN);

    logic [C_W-1:0]   cnt_q [1:MAX_LEN];
    logic [SYM_W-1:0] sym_q [0:SYM_N-1];
    logic             cnt_wr_s;

    // Length 0 and lengths beyond MAX_LEN have no table entry; writes there are dropped.
    assign cnt_wr_s = cnt_we_i && (cnt_waddr_i != {L_W{1'b0}}) && (cnt_waddr_i <= LEN_MAX);

    // Count table: cleared by reset only, so a soft clear keeps the loaded codebook.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= MAX_LEN; i++) begin
                cnt_q[i] <= {C_W{1'b0}};
            end
        end else if (cnt_wr_s) begin
            cnt_q[cnt_waddr_i] <= cnt_wdata_i;
        end
    end

    // Symbol table: cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_N; i++) begin
                sym_q[i] <= {SYM_W{1'b0}};
            end
        end else if (sym_we_i) begin
            sym_q[sym_waddr_i] <= sym_wdata_i;
        end
    end

    // Count read for the length being tested; out-of-range lengths read as zero codes.
    always_comb begin
        cnt_rdata_o = {C_W{1'b0}};
        if ((cnt_raddr_i != {L_W{1'b0}}) && (cnt_raddr_i <= LEN_MAX)) begin
            cnt_rdata_o = cnt_q[cnt_raddr_i];
        end else begin
            cnt_rdata_o = {C_W{1'b0}};
        end
    end

    assign sym_rdata_o = sym_q[sym_raddr_i];

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial canonical Huffman decoder: walks the canonical tables one code bit per cycle.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int SYM_W   = SYM_W_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    huffman_decoder_if.slave bus
);
    localparam int L_W = $clog2(MAX_LEN + 1);
    localparam int C_W = SYM_W + 1;
    localparam int A_W = MAX_LEN + 1;
    localparam logic [L_W-1:0] LEN_MAX  = L_W'(MAX_LEN);
    localparam logic [A_W-1:0] IDX_LIM  = A_W'(2 ** SYM_W);

    state_e           state_q, state_d;
    logic [MAX_LEN-1:0] code_q, code_d;
    logic [A_W-1:0]   first_q, first_d;
    logic [A_W-1:0]   index_q, index_d;
    logic [L_W-1:0]   len_q, len_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic [L_W-1:0]   out_len_q, out_len_d;
    logic             err_q, err_d;

    logic [L_W-1:0]   len_nx_s;
    logic [A_W-1:0]   c_s, diff_s, idx_s, cnt_ext_s, sum_s;
    logic [C_W-1:0]   cnt_rd_s;
    logic [SYM_W-1:0] sym_rd_s;
    logic             hit_s, in_ready_s, accept_s;

    huff_canon_tables #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) u_tables (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_we_i    (bus.cnt_we),
        .cnt_waddr_i (bus.cnt_addr),
        .cnt_wdata_i (bus.cnt_data),
        .sym_we_i    (bus.sym_we),
        .sym_waddr_i (bus.sym_addr),
        .sym_wdata_i (bus.sym_data),
        .cnt_raddr_i (len_nx_s),
        .cnt_rdata_o (cnt_rd_s),
        .sym_raddr_i (idx_s[SYM_W-1:0]),
        .sym_rdata_o (sym_rd_s)
    );

    // Canonical walk datapath for the candidate length len+1.
    always_comb begin
        len_nx_s  = len_q + L_W'(1);
        c_s       = {code_q, bus.in_bit};
        cnt_ext_s = A_W'(cnt_rd_s);
        diff_s    = c_s - first_q;
        idx_s     = index_q + diff_s;
        sum_s     = first_q + cnt_ext_s;
        hit_s     = (cnt_rd_s != {C_W{1'b0}}) && (diff_s < cnt_ext_s);
    end

    // A new bit is only taken when its possible symbol has somewhere to go; held low in reset.
    assign in_ready_s = rst_n && (state_q == DECODE) && (!out_valid_q || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Next-state logic: soft clear first, then output handshake, then the per-bit walk.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        first_d     = first_q;
        index_d     = index_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_len_d   = out_len_q;
        err_d       = err_q;
        if (bus.clr) begin
            state_d     = DECODE;
            code_d      = {MAX_LEN{1'b0}};
            first_d     = {A_W{1'b0}};
            index_d     = {A_W{1'b0}};
            len_d       = {L_W{1'b0}};
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            case (state_q)
                DECODE: begin
                    if (accept_s) begin
                        if (hit_s || (len_nx_s == LEN_MAX)) begin
                            // Codeword finished (or abandoned): the walk restarts from length 1.
                            code_d  = {MAX_LEN{1'b0}};
                            first_d = {A_W{1'b0}};
                            index_d = {A_W{1'b0}};
                            len_d   = {L_W{1'b0}};
                        end else begin
                            code_d  = c_s[MAX_LEN-1:0];
                            first_d = sum_s + sum_s;
                            index_d = index_q + cnt_ext_s;
                            len_d   = len_nx_s;
                        end
                        if (hit_s && (idx_s < IDX_LIM)) begin
                            out_valid_d = 1'b1;
                            out_sym_d   = sym_rd_s;
                            out_len_d   = len_nx_s;
                        end else if (hit_s || (len_nx_s == LEN_MAX)) begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = DECODE;
                        end
                    end else begin
                        state_d = DECODE;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DECODE;
            code_q      <= {MAX_LEN{1'b0}};
            first_q     <= {A_W{1'b0}};
            index_q     <= {A_W{1'b0}};
            len_q       <= {L_W{1'b0}};
            out_valid_q <= 1'b0;
            out_sym_q   <= {SYM_W{1'b0}};
            out_len_q   <= {L_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            first_q     <= first_d;
            index_q     <= index_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_len_q   <= out_len_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_len   = out_len_q;
    assign bus.busy      = (len_q != {L_W{1'b0}});
    assign bus.err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: vector table for streaming decode plus corner sequences.
module tb_huffman_decoder;
    import huffman_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   hs_cnt = 0;
    int   acc_cnt = 0;
    int   hs0, acc0;

    always #5 clk = ~clk;

    huffman_decoder_if #(.MAX_LEN(16), .SYM_W(8)) bus ();

    huffman_decoder #(.MAX_LEN(16), .SYM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Count output handshakes and accepted bits at each active edge.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hs_cnt++;
        if (bus.in_valid && bus.in_ready) acc_cnt++;
    end

    typedef struct {
        logic             b;
        logic             v;
        logic [7:0]       sym;
        logic [LEN_W-1:0] len;
        logic             busy;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_cnt(input int a, input int d);
        bus.cnt_we   = 1'b1;
        bus.cnt_addr = LEN_W'(a);
        bus.cnt_data = CNT_W'(d);
        tick();
        bus.cnt_we   = 1'b0;
    endtask

    task automatic load_sym(input int a, input int d);
        bus.sym_we   = 1'b1;
        bus.sym_addr = 8'(a);
        bus.sym_data = 8'(d);
        tick();
        bus.sym_we   = 1'b0;
    endtask

    task automatic load_book1();
        load_cnt(1, 1);
        load_cnt(2, 1);
        load_cnt(3, 2);
        for (int i = 0; i < 4; i++) load_sym(i, 8'h41 + i);
    endtask

    task automatic send(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.clr = 1'b0; bus.cnt_we = 1'b0; bus.cnt_addr = '0; bus.cnt_data = '0;
        bus.sym_we = 1'b0; bus.sym_addr = '0; bus.sym_data = '0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sym", bus.out_sym, 0);
        check("rst_out_len", bus.out_len, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);

        // Streaming decode: 0,10,110,111 then 10,0 (handshake and new 1-bit code together)
        vt[0]  = '{1'b0, 1'b1, 8'h41, 5'd1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 8'h42, 5'd2, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 8'h43, 5'd3, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 8'h44, 5'd3, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'h42, 5'd2, 1'b0};
        vt[11] = '{1'b0, 1'b1, 8'h41, 5'd1, 1'b0};
        load_book1();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vt[i].b);
            check($sformatf("vec%0d_valid", i), bus.out_valid, vt[i].v);
            check($sformatf("vec%0d_busy", i), bus.busy, vt[i].busy);
            if (vt[i].v) begin
                check($sformatf("vec%0d_sym", i), bus.out_sym, vt[i].sym);
                check($sformatf("vec%0d_len", i), bus.out_len, vt[i].len);
            end
        end

        // Backpressure: three 0 bits with out_ready low, then released
        do_reset();
        load_book1();
        bus.out_ready = 1'b0;
        hs0 = hs_cnt;
        acc0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.in_bit = 1'b0;
        tick();
        check("bp_valid", bus.out_valid, 1);
        check("bp_sym", bus.out_sym, 8'h41);
        check("bp_in_ready", bus.in_ready, 0);
        tick();
        tick();
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_sym", bus.out_sym, 8'h41);
        check("bp_hold_acc", acc_cnt - acc0, 1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_rel1_valid", bus.out_valid, 1);
        check("bp_rel1_sym", bus.out_sym, 8'h41);
        tick();
        bus.in_valid = 1'b0;
        check("bp_rel2_valid", bus.out_valid, 1);
        tick();
        check("bp_drain_valid", bus.out_valid, 0);
        check("bp_hs_count", hs_cnt - hs0, 3);
        check("bp_acc_count", acc_cnt - acc0, 3);

        // Invalid code: single-symbol book, sixteen 1 bits
        do_reset();
        load_cnt(1, 1);
        load_sym(0, 8'h41);
        for (int i = 0; i < 15; i++) send(1'b1);
        check("len15_err", bus.err, 0);
        check("len15_busy", bus.busy, 1);
        send(1'b1);
        check("len16_err", bus.err, 1);
        check("len16_in_ready", bus.in_ready, 0);
        check("len16_busy", bus.busy, 0);
        check("len16_valid", bus.out_valid, 0);
        send(1'b0);
        check("errstate_no_out", bus.out_valid, 0);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_err", bus.err, 0);
        check("clr_in_ready", bus.in_ready, 1);
        send(1'b0);
        check("after_clr_valid", bus.out_valid, 1);
        check("after_clr_sym", bus.out_sym, 8'h41);
        check("after_clr_len", bus.out_len, 1);
        // clr wins over a bit accepted in the same cycle
        send(1'b1);
        bus.clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit = 1'b0;
        tick();
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_prio_busy", bus.busy, 0);
        check("clr_prio_valid", bus.out_valid, 0);
        // clr drops a held symbol
        bus.out_ready = 1'b0;
        send(1'b0);
        check("held_valid", bus.out_valid, 1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_drops_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;

        // Reset in the middle of a codeword
        do_reset();
        load_book1();
        send(1'b1);
        send(1'b1);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load_book1();
        send(1'b1);
        send(1'b1);
        send(1'b0);
        check("after_rst_valid", bus.out_valid, 1);
        check("after_rst_sym", bus.out_sym, 8'h43);
        check("after_rst_len", bus.out_len, 3);

        // Index overflow: cnt[1]=1, cnt[9]=256, code of nine 1s gives index 1+255=256
        do_reset();
        load_cnt(1, 1);
        load_cnt(9, 256);
        load_sym(0, 8'h41);
        hs0 = hs_cnt;
        for (int i = 0; i < 8; i++) send(1'b1);
        check("ovf_len8_err", bus.err, 0);
        check("ovf_len8_busy", bus.busy, 1);
        send(1'b1);
        check("ovf_err", bus.err, 1);
        check("ovf_valid", bus.out_valid, 0);
        check("ovf_in_ready", bus.in_ready, 0);
        check("ovf_no_hs", hs_cnt - hs0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
